// File: rtl/trinity_link_rx_if.sv
// -----------------------------------------------------------------------------
// trinity_link_rx_if
// Bundles the two streaming sides of the Trinity link receiver:
//   - inbound link bytes from the neighbour tile (uii_link_in, link_vld)
//   - outbound payload stream toward the consumer
//     (rx_data, rx_op, rx_last, rx_valid, rx_ready)
// Modports:
//   slave  : the receiver itself (samples link bytes, presents payload)
//   master : the environment (drives link bytes, consumes payload)
// -----------------------------------------------------------------------------
interface trinity_link_rx_if;
   logic [7:0] uii_link_in;
   logic       link_vld;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic [1:0] rx_op;
   logic       rx_last;
   logic       rx_valid;

   modport slave (
      input  uii_link_in, link_vld, rx_ready,
      output rx_data, rx_op, rx_last, rx_valid
   );

   modport master (
      output uii_link_in, link_vld, rx_ready,
      input  rx_data, rx_op, rx_last, rx_valid
   );
endinterface

// File: rtl/trinity_link_rx.sv
// -----------------------------------------------------------------------------
// trinity_link_rx
// Receives framed bytes from a neighbour tile's broadcast bus, strips the
// header (and optional checksum), and queues payload bytes in a small FIFO
// tagged with the frame opcode and an end-of-frame marker.
//
// Frame: header {2'b10, op[1:0], len[3:0]} (len 1..15), len payload bytes,
//        then one checksum byte (XOR of header and payload) when enabled.
//
// Ports:
//   sys_clk    : single clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   link       : trinity_link_rx_if.slave (link bytes in, payload stream out)
//   err_clr    : synchronous clear of err_cnt and ovf (wins over new errors)
//   busy       : FSM is inside a frame
//   ovf        : sticky, a payload byte was dropped on a full FIFO
//   err_cnt    : saturating count of header and checksum errors
//
// Parameter FIFO_DEPTH : payload FIFO entries, 2/4/8/16.
// Macro TRINITY_LINK_RX_CHKSUM_EN : when defined, frames carry a checksum
//   byte that is verified in a CHECK state; when undefined there is no
//   CHECK state and frames end after the last payload byte.
// -----------------------------------------------------------------------------
module trinity_link_rx #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   trinity_link_rx_if.slave    link,
   input  logic                err_clr,
   output logic                busy,
   output logic                ovf,
   output logic [7:0]          err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

`ifdef TRINITY_LINK_RX_CHKSUM_EN
   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
`else
   typedef enum logic {IDLE, PAYLOAD} state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [3:0]  len_q, len_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  csum_q, csum_d;
   logic        push, push_last, hdr_err, csum_err;

   // FIFO entry layout: {op[1:0], last, data[7:0]}
   logic [10:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic        empty, full, pop, push_ok, drop;
   logic [10:0] head;

   // Frame parser state register; everything inside a frame is dropped
   // on reset so the next sampled byte is treated as a header.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         op_q    <= 2'd0;
         len_q   <= 4'd0;
         cnt_q   <= 4'd0;
         csum_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
      end
   end

   // Next-state logic. Nothing advances unless link_vld qualifies the byte,
   // so idle gaps mid-frame are simply held. The running XOR is kept even
   // without the checksum stage; it is then just unused.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      push      = 1'b0;
      push_last = 1'b0;
      hdr_err   = 1'b0;
      csum_err  = 1'b0;
      case (state_q)
         IDLE: begin
            if (link.link_vld) begin
               if (link.uii_link_in[7:6] == 2'b10 && link.uii_link_in[3:0] != 4'd0) begin
                  state_d = PAYLOAD;
                  op_d    = link.uii_link_in[5:4];
                  len_d   = link.uii_link_in[3:0];
                  cnt_d   = 4'd0;
                  csum_d  = link.uii_link_in;
               end else begin
                  hdr_err = 1'b1;
               end
            end
         end
         PAYLOAD: begin
            if (link.link_vld) begin
               push      = 1'b1;
               push_last = (cnt_q == len_q - 4'd1);
               cnt_d     = cnt_q + 4'd1;
               csum_d    = csum_q ^ link.uii_link_in;
               if (push_last) begin
`ifdef TRINITY_LINK_RX_CHKSUM_EN
                  state_d = CHECK;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
`ifdef TRINITY_LINK_RX_CHKSUM_EN
         CHECK: begin
            if (link.link_vld) begin
               csum_err = (link.uii_link_in != csum_q);
               state_d  = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   // A push into a full FIFO is only accepted when the head leaves on the
   // same edge, keeping occupancy constant.
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop     = !empty && link.rx_ready;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   // FIFO storage is not reset; outputs are masked while empty instead.
   always_ff @(posedge sys_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {op_q, push_last, link.uii_link_in};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head          = mem[rd_ptr];
   assign link.rx_valid = !empty;
   assign link.rx_data  = empty ? 8'd0 : head[7:0];
   assign link.rx_last  = empty ? 1'b0 : head[8];
   assign link.rx_op    = empty ? 2'd0 : head[10:9];

   // Error bookkeeping: err_clr takes priority over any error on the same edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         err_cnt <= 8'd0;
         ovf     <= 1'b0;
      end else if (err_clr) begin
         err_cnt <= 8'd0;
         ovf     <= 1'b0;
      end else begin
         if ((hdr_err || csum_err) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (drop) ovf <= 1'b1;
      end
   end

endmodule

// File: doc/trinity_link_rx.md
TRINITY_LINK_RX -- requirements
Module: trinity_link_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set payload FIFO entries; legal values are 2, 4, 8 and 16 (powers of two).
REQ-002 sys_clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 uii_link_in  input  8  link byte from the neighbour tile's broadcast bus.
REQ-005 link_vld  input  1  qualifier; uii_link_in SHALL be sampled only when link_vld=1.
REQ-006 rx_ready  input  1  consumer accepts the current FIFO head.
REQ-007 err_clr  input  1  synchronous clear of err_cnt and ovf.
REQ-008 rx_data  output  8  payload byte at the FIFO head.
REQ-009 rx_op  output  2  opcode of the frame that carried the head byte.
REQ-010 rx_last  output  1  head byte is the final payload byte of its frame.
REQ-011 rx_valid  output  1  FIFO non-empty.
REQ-012 busy  output  1  FSM is not in IDLE.
REQ-013 ovf  output  1  sticky flag: a payload byte was dropped.
REQ-014 err_cnt  output  8  saturating count of framing and checksum errors.

Function
REQ-015 Frame format SHALL be as follows.
- Header: [7:6]=2'b10, [5:4]=op, [3:0]=LEN, where LEN 1..15 is the payload byte count.
- Then LEN payload bytes.
- Then one checksum byte, equal to the XOR of the header and all payload bytes.
REQ-016 FSM states SHALL be IDLE, PAYLOAD and CHECK, with these transitions.
- IDLE->PAYLOAD on a valid header.
- PAYLOAD->CHECK after the LEN-th payload byte.
- CHECK->IDLE on the checksum byte.
- A state SHALL advance only on edges where link_vld=1.
REQ-017 In IDLE, a sampled byte whose [7:6] is not 2'b10, or whose LEN is 0, SHALL be discarded, increment err_cnt by one, and leave the FSM in IDLE.
REQ-018 Each payload byte SHALL be written to the FIFO at its sampling edge, tagged with {op, last}; rx_valid SHALL be high after that same edge when the FIFO was empty (one-edge latency).
REQ-019 The FIFO head SHALL be popped on an edge where rx_valid=1 and rx_ready=1; the order of rx_data, rx_op and rx_last SHALL be preserved.
REQ-020 A payload byte arriving while the FIFO is full and no pop occurs SHALL be dropped, and ovf SHALL be set; the FSM byte count SHALL still advance.
REQ-021 Full FIFO with a simultaneous push and pop SHALL accept both; occupancy SHALL be unchanged.
REQ-022 A checksum mismatch SHALL increment err_cnt by one; already-queued payload is not retracted.
REQ-023 err_cnt SHALL saturate at 0xFF.
REQ-024 If err_clr coincides with an error event, err_clr SHALL win: err_cnt=0 and ovf=0.
REQ-025 Gaps with link_vld=0 mid-frame SHALL be tolerated indefinitely; there is no timeout.
REQ-026 busy SHALL be high in PAYLOAD and CHECK.

Reset
REQ-027 Assertion of sys_rst_n=0, including mid-frame, SHALL immediately force all of the following.
- FSM to IDLE.
- FIFO to empty.
- rx_valid=0, rx_data=0, rx_op=0, rx_last=0.
- busy=0, ovf=0, err_cnt=0.
REQ-028 The first byte sampled after deassertion SHALL be treated as a potential header.

Configuration
REQ-029 Macro TRINITY_LINK_RX_CHKSUM_EN SHALL control the checksum stage.
- Defined: the CHECK state and checksum comparison SHALL be present.
- Undefined: CHECK SHALL be absent, frames SHALL carry no checksum byte, and PAYLOAD SHALL go directly to IDLE after the LEN-th byte.
- Undefined: only the header errors of REQ-017 SHALL increment err_cnt.

Verification
REQ-030 Good frame (CHKSUM_EN defined), rx_ready=1: bytes 0x93,0x11,0x22,0x33,0x93 -> rx_data 0x11,0x22,0x33 with rx_op=1, rx_last only on 0x33, err_cnt=0, busy low after the fifth byte.
REQ-031 Bad checksum: frame 0x81,0x5A,0x00 -> 0x5A delivered, err_cnt=1; a following good frame 0x81,0x5A,0xDB -> err_cnt stays 1.
REQ-032 Overflow: rx_ready=0, FIFO_DEPTH=8, frame LEN=10 (0x8A plus 10 bytes plus checksum) -> 8 entries held, ovf=1, FSM back to IDLE; draining yields the first 8 bytes in order.
REQ-033 Framing error and saturation: 300 bytes of 0x00 in IDLE -> err_cnt=0xFF, FSM stays IDLE; then err_clr=1 -> err_cnt=0, ovf=0.
REQ-034 Reset mid-frame: after 0x94,0x01 (2 of 4 payload bytes), pulse sys_rst_n low -> rx_valid=0, busy=0; then frame 0x91,0x7E,0xEF -> 0x7E delivered with rx_op=1, rx_last=1.
REQ-035 Macro undefined: frame 0xA2,0x10,0x20 -> both bytes delivered with rx_op=2; the next byte 0x81 is accepted as a header.
